gpio_irq_controller: RTL and testbench
======================================

// Module: gpio_irq_controller
// PURPOSE
//  Wishbone-slave GPIO block for the monitor FPGA. Supports up to 64 pins in 16-bit banks.
//  Per pin: output enable, output value, dedicated-function enable.
//  Input path: 2-FF synchroniser, then a tick-based glitch filter.
//  Adds atomic set/clear of outputs and per-pin rising/falling edge capture with a level IRQ output.
//  Sits on the 16-bit system Wishbone bus next to the other monitor peripherals.
// PARAMETERS
//  NUM_GPIO      12  pin count, 1..64; NUM_BANKS = ceil(NUM_GPIO/16)
//  OE_DEFAULTS   0   reset value of OE register (NUM_GPIO bits)
//  OUT_DEFAULTS  0   reset value of OUT register
//  DED_DEFAULTS  0   reset value of DED_EN register
//  FILTER_LEN    3   consecutive ticks a new level must persist; 0 = filter bypassed; max 15
//  FILT_DIV_DEF  0   reset value of filter prescaler divisor
// PORTS
//  wb_clk_i   in   1         system clock, all logic on rising edge
//  wb_rst_i   in   1         synchronous active-high reset
//  wb_cyc_i   in   1         Wishbone cycle
//  wb_stb_i   in   1         Wishbone strobe
//  wb_we_i    in   1         1 = write
//  wb_adr_i   in   16        [3:0] register, [5:4] bank; [15:6] ignored
//  wb_dat_i   in   16        write data
//  wb_dat_o   out  16        read data, registered, valid while wb_ack_o = 1
//  wb_ack_o   out  1         single-cycle acknowledge
//  gpio_oe    out  NUM_GPIO  output enables
//  gpio_out   out  NUM_GPIO  output values
//  gpio_in    in   NUM_GPIO  raw asynchronous pad inputs
//  ded_en     out  NUM_GPIO  dedicated-function enables
//  irq_o      out  1         level interrupt, registered
// BEHAVIOUR
//  Bus
//   - Ack: wb_ack_o asserts the cycle after cyc & stb & !ack, for one cycle.
//     Back-to-back strobes therefore ack on every other cycle.
//   - Writes take effect on the ack edge.
//   - Reads: registered; data is captured on the same edge that raises ack.
//   - Bits >= NUM_GPIO, banks >= NUM_BANKS and unmapped registers read 0; writes to them are ignored.
//  Register map (reg = adr[3:0], per bank b covering pins 16b..16b+15)
//   0 OE RW | 1 OUT RW | 2 IN RO (filtered) | 3 DED_EN RW
//   4 OUT_SET WO: OUT |= dat | 5 OUT_CLR WO: OUT &= ~dat (both read 0)
//   6 IRQ_EN RW | 7 RISE_EN RW | 8 FALL_EN RW
//   9 IRQ_STAT R/W1C: written 1s clear, written 0s have no effect
//   10 FILT_DIV RW, 16-bit, global; bank 0 only, other banks read 0
//  Input filter
//   - gpio_in passes through 2 sync flops (s1, s2).
//   - Prescaler counter runs 0..FILT_DIV and emits a 1-cycle tick on wrap. FILT_DIV = 0 gives a tick every cycle.
//   - Writing FILT_DIV restarts the prescaler at 0.
//   - Per pin, 4-bit run counter: cleared whenever s2 == filt; incremented on a tick while s2 != filt.
//   - When the counter reaches FILTER_LEN, filt <= s2 and the counter clears.
//   - FILTER_LEN = 0: filt <= s2 every cycle.
//   - Worst-case latency, pad to IN: 2 + 1 + FILTER_LEN*(FILT_DIV+1) cycles.
//  Edge capture
//   - filt_d is filt delayed one cycle.
//   - rise = filt & ~filt_d; fall = ~filt & filt_d.
//   - STAT[i] sets if (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
//     STAT records edges regardless of IRQ_EN.
//   - Set and W1C on the same bit in the same cycle: set wins (STAT stays 1).
//   - irq_o <= |(STAT & IRQ_EN), registered, so it lags STAT by one cycle.
//     Clearing IRQ_EN masks irq_o; STAT is kept.
//  OUT_SET / OUT_CLR are single-cycle read-modify-write and do not race: only one write per ack.
//  Reset (sync, whole block)
//   - OE/OUT/DED_EN <= defaults; IRQ_EN, RISE_EN, FALL_EN, STAT <= 0; FILT_DIV <= FILT_DIV_DEF.
//   - s1, s2, filt, filt_d, run counters, prescaler <= 0; wb_ack_o, wb_dat_o, irq_o <= 0.
//   - Reset during a bus cycle drops the pending ack; the master must retry.
//   - A pin high at reset release produces a rise once filtered. It is not captured because RISE_EN = 0.
// TESTING
//  1 Reset with OUT_DEFAULTS=12'h0A5 -> read reg1 = 0x00A5, reg6..9 = 0, irq_o = 0; ack exactly 1 cycle after stb.
//  2 Write OUT=0x00F0, OUT_SET 0x000F, OUT_CLR 0x0030 -> gpio_out = 0x0CF; read reg4/5 -> 0.
//  3 FILTER_LEN=3, FILT_DIV=0: pulse gpio_in[0] high 2 cycles -> IN bit0 stays 0.
//    Hold 10 cycles -> bit0 = 1 within 6 cycles.
//  4 RISE_EN=IRQ_EN=0x1, drive pin0 0->1 -> STAT=0x1, irq_o=1.
//    Write STAT 0x1 -> irq_o=0 two cycles later. Fall with FALL_EN=0 -> no set.
//  5 W1C of bit0 in the same cycle as a new rise on pin0 -> STAT bit0 remains 1.
//  6 NUM_GPIO=40: bank 2 write OE=0xFFFF -> gpio_oe[39:32]=0xFF; read back 0x00FF; bank 3 reads 0.

Source files
------------

// File: rtl/gpio_irq_controller.sv
// gpio_irq_controller
// Wishbone-slave GPIO block: up to 64 pins in 16-bit banks, per-pin OE/OUT/dedicated
// enables, synchronised and glitch-filtered inputs, edge capture and a level IRQ.
module gpio_irq_controller #(
    parameter int                  NUM_GPIO     = 12,
    parameter logic [NUM_GPIO-1:0] OE_DEFAULTS  = '0,
    parameter logic [NUM_GPIO-1:0] OUT_DEFAULTS = '0,
    parameter logic [NUM_GPIO-1:0] DED_DEFAULTS = '0,
    parameter int                  FILTER_LEN   = 3,
    parameter logic [15:0]         FILT_DIV_DEF = '0
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [15:0]         wb_adr_i,
    input  logic [15:0]         wb_dat_i,
    output logic [15:0]         wb_dat_o,
    output logic                wb_ack_o,
    output logic [NUM_GPIO-1:0] gpio_oe,
    output logic [NUM_GPIO-1:0] gpio_out,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] ded_en,
    output logic                irq_o
);

    localparam logic [3:0] FLEN = 4'(FILTER_LEN);

    typedef enum logic [3:0] {
        REG_OE       = 4'd0,
        REG_OUT      = 4'd1,
        REG_IN       = 4'd2,
        REG_DED_EN   = 4'd3,
        REG_OUT_SET  = 4'd4,
        REG_OUT_CLR  = 4'd5,
        REG_IRQ_EN   = 4'd6,
        REG_RISE_EN  = 4'd7,
        REG_FALL_EN  = 4'd8,
        REG_IRQ_STAT = 4'd9,
        REG_FILT_DIV = 4'd10
    } reg_e;

    reg_e                reg_sel;
    logic [1:0]          bank_sel;
    logic                unused_adr;
    logic                bus_hit;
    logic                wr_hit;
    logic                fdiv_wr;

    logic [NUM_GPIO-1:0] lane_sel;
    logic [NUM_GPIO-1:0] lane_dat;
    logic [NUM_GPIO-1:0] wr_bits;

    logic [NUM_GPIO-1:0] oe_q;
    logic [NUM_GPIO-1:0] out_q;
    logic [NUM_GPIO-1:0] ded_q;
    logic [NUM_GPIO-1:0] irq_en_q;
    logic [NUM_GPIO-1:0] rise_en_q;
    logic [NUM_GPIO-1:0] fall_en_q;
    logic [NUM_GPIO-1:0] stat_q;
    logic [15:0]         filt_div_q;

    logic [15:0]         presc_q;
    logic                tick;
    logic [NUM_GPIO-1:0] s1_q;
    logic [NUM_GPIO-1:0] s2_q;
    logic [NUM_GPIO-1:0] filt_q;
    logic [NUM_GPIO-1:0] filt_d_q;
    logic [3:0]          run_q [NUM_GPIO];

    logic [NUM_GPIO-1:0] rise;
    logic [NUM_GPIO-1:0] fall;
    logic [NUM_GPIO-1:0] stat_set;
    logic [NUM_GPIO-1:0] stat_clr;

    logic [63:0]         rd_pad;
    logic [15:0]         rd_data;

    assign reg_sel    = reg_e'(wb_adr_i[3:0]);
    assign bank_sel   = wb_adr_i[5:4];
    assign unused_adr = ^wb_adr_i[15:6];

    // A new request is one not already being acknowledged, so a held strobe acks every other cycle
    assign bus_hit = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_hit  = bus_hit & wb_we_i;
    assign fdiv_wr = wr_hit && (reg_sel == REG_FILT_DIV) && (bank_sel == 2'd0);

    // Map the 16-bit bus lane onto the pins of the addressed bank; pins past NUM_GPIO simply do not exist
    always_comb begin
        lane_sel = '0;
        lane_dat = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            lane_sel[i] = (bank_sel == 2'(i / 16));
            lane_dat[i] = wb_dat_i[i % 16];
        end
    end

    assign wr_bits = lane_dat & lane_sel;

    // Control registers, updated on the edge that raises ack
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            oe_q       <= OE_DEFAULTS;
            out_q      <= OUT_DEFAULTS;
            ded_q      <= DED_DEFAULTS;
            irq_en_q   <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            filt_div_q <= FILT_DIV_DEF;
        end else if (wr_hit) begin
            case (reg_sel)
                REG_OE:       oe_q      <= (oe_q & ~lane_sel) | wr_bits;
                REG_OUT:      out_q     <= (out_q & ~lane_sel) | wr_bits;
                REG_DED_EN:   ded_q     <= (ded_q & ~lane_sel) | wr_bits;
                REG_OUT_SET:  out_q     <= out_q | wr_bits;
                REG_OUT_CLR:  out_q     <= out_q & ~wr_bits;
                REG_IRQ_EN:   irq_en_q  <= (irq_en_q & ~lane_sel) | wr_bits;
                REG_RISE_EN:  rise_en_q <= (rise_en_q & ~lane_sel) | wr_bits;
                REG_FALL_EN:  fall_en_q <= (fall_en_q & ~lane_sel) | wr_bits;
                REG_FILT_DIV: begin
                    if (bank_sel == 2'd0) begin
                        filt_div_q <= wb_dat_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tick = (presc_q == filt_div_q);

    // Filter prescaler: counts 0..FILT_DIV, restarting whenever the divisor is rewritten
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            presc_q <= '0;
        end else if (fdiv_wr || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 16'd1;
        end
    end

    // Synchroniser and per-pin glitch filter: a new level must survive FILTER_LEN ticks
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1_q     <= '0;
            s2_q     <= '0;
            filt_q   <= '0;
            filt_d_q <= '0;
            for (int i = 0; i < NUM_GPIO; i++) begin
                run_q[i] <= '0;
            end
        end else begin
            s1_q     <= gpio_in;
            s2_q     <= s1_q;
            filt_d_q <= filt_q;
            for (int i = 0; i < NUM_GPIO; i++) begin
                if (FILTER_LEN == 0) begin
                    filt_q[i] <= s2_q[i];
                    run_q[i]  <= '0;
                end else if (s2_q[i] == filt_q[i]) begin
                    run_q[i] <= '0;
                end else if (tick) begin
                    if (run_q[i] + 4'd1 == FLEN) begin
                        filt_q[i] <= s2_q[i];
                        run_q[i]  <= '0;
                    end else begin
                        run_q[i] <= run_q[i] + 4'd1;
                    end
                end
            end
        end
    end

    assign rise     = filt_q & ~filt_d_q;
    assign fall     = ~filt_q & filt_d_q;
    assign stat_set = (rise & rise_en_q) | (fall & fall_en_q);
    assign stat_clr = (wr_hit && (reg_sel == REG_IRQ_STAT)) ? wr_bits : '0;

    // Edge status: write-one-to-clear, a fresh edge in the same cycle keeps the bit set
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stat_q <= '0;
        end else begin
            stat_q <= (stat_q & ~stat_clr) | stat_set;
        end
    end

    // Level interrupt, one cycle behind the status register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |(stat_q & irq_en_q);
        end
    end

    // Read mux: registers are zero-padded to 64 pins so absent bits and banks read 0
    always_comb begin
        rd_pad  = '0;
        rd_data = '0;
        case (reg_sel)
            REG_OE:       rd_pad[NUM_GPIO-1:0] = oe_q;
            REG_OUT:      rd_pad[NUM_GPIO-1:0] = out_q;
            REG_IN:       rd_pad[NUM_GPIO-1:0] = filt_q;
            REG_DED_EN:   rd_pad[NUM_GPIO-1:0] = ded_q;
            REG_IRQ_EN:   rd_pad[NUM_GPIO-1:0] = irq_en_q;
            REG_RISE_EN:  rd_pad[NUM_GPIO-1:0] = rise_en_q;
            REG_FALL_EN:  rd_pad[NUM_GPIO-1:0] = fall_en_q;
            REG_IRQ_STAT: rd_pad[NUM_GPIO-1:0] = stat_q;
            default: ;
        endcase
        rd_data = rd_pad[{bank_sel, 4'b0000} +: 16];
        if (reg_sel == REG_FILT_DIV) begin
            rd_data = (bank_sel == 2'd0) ? filt_div_q : 16'h0000;
        end
    end

    // Bus response: ack and read data are registered together on the request edge
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= bus_hit;
            wb_dat_o <= bus_hit ? rd_data : 16'h0000;
        end
    end

    assign gpio_oe  = oe_q;
    assign gpio_out = out_q;
    assign ded_en   = ded_q;

endmodule

// File: tb/tb_gpio_irq_controller.sv
// tb_gpio_irq_controller
// Self-checking bench for gpio_irq_controller with 40 pins (three banks, the last one partial).
module tb_gpio_irq_controller;

    localparam int NUM = 40;

    logic           wb_clk_i = 1'b0;
    logic           wb_rst_i = 1'b1;
    logic           wb_cyc_i = 1'b0;
    logic           wb_stb_i = 1'b0;
    logic           wb_we_i  = 1'b0;
    logic [15:0]    wb_adr_i = '0;
    logic [15:0]    wb_dat_i = '0;
    logic [15:0]    wb_dat_o;
    logic           wb_ack_o;
    logic [NUM-1:0] gpio_oe;
    logic [NUM-1:0] gpio_out;
    logic [NUM-1:0] gpio_in = '0;
    logic [NUM-1:0] ded_en;
    logic           irq_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: one 64-bit image per register number, plus the global divisor
    logic [63:0] m_reg [16];
    logic [15:0] m_fdiv;

    typedef struct packed {
        logic [7:0]  pulse;
        logic [15:0] div;
        logic        expect_stat;
    } filt_vec_t;

    filt_vec_t vecs [8];

    gpio_irq_controller #(
        .NUM_GPIO     (NUM),
        .OE_DEFAULTS  ('0),
        .OUT_DEFAULTS (40'h00_0000_00A5),
        .DED_DEFAULTS ('0),
        .FILTER_LEN   (3),
        .FILT_DIV_DEF (16'h0000)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .gpio_oe  (gpio_oe),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .ded_en   (ded_en),
        .irq_o    (irq_o)
    );

    // 100 MHz system clock
    always #5 wb_clk_i = ~wb_clk_i;

    // Safety net so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // One Wishbone transfer; ack must arrive exactly one cycle after the strobe
    task automatic bus_xfer(input logic we, input logic [3:0] r, input logic [1:0] b,
                            input logic [15:0] d, output logic [15:0] q);
        int n;
        @(posedge wb_clk_i);
        #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = {10'($urandom), b, r};
        wb_dat_i = d;
        n = 0;
        do begin
            @(posedge wb_clk_i);
            #1;
            n++;
        end while (!wb_ack_o && n < 4);
        check_output("ack_latency", 64'(n), 64'd1);
        q = wb_dat_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] r, input logic [1:0] b, input logic [15:0] d);
        logic [15:0] dummy;
        bus_xfer(1'b1, r, b, d, dummy);
    endtask

    task automatic bus_read(input logic [3:0] r, input logic [1:0] b, output logic [15:0] q);
        bus_xfer(1'b0, r, b, 16'h0000, q);
    endtask

    // Model a register write following the register map rules, pin by pin
    task automatic model_write(input int r, input int b, input logic [15:0] d);
        for (int k = 0; k < 16; k++) begin
            int pin;
            pin = b * 16 + k;
            if (pin < NUM) begin
                case (r)
                    0, 1, 3, 6, 7, 8: m_reg[r][pin] = d[k];
                    4: if (d[k]) m_reg[1][pin] = 1'b1;
                    5: if (d[k]) m_reg[1][pin] = 1'b0;
                    9: if (d[k]) m_reg[9][pin] = 1'b0;
                    default: ;
                endcase
            end
        end
        if (r == 10 && b == 0) m_fdiv = d;
    endtask

    function automatic logic [15:0] model_read(input int r, input int b);
        logic [15:0] v;
        v = '0;
        if (r == 10) begin
            v = (b == 0) ? m_fdiv : 16'h0000;
        end else if (r <= 3 || (r >= 6 && r <= 9)) begin
            for (int k = 0; k < 16; k++) begin
                if (b * 16 + k < NUM) v[k] = m_reg[r][b * 16 + k];
            end
        end
        return v;
    endfunction

    // Drive one filter vector: set divisor, clear STAT, pulse pin 0, then see whether a rise was captured
    task automatic apply_stimulus(input filt_vec_t v);
        logic [15:0] q;
        bus_write(4'd10, 2'd0, v.div);
        bus_write(4'd9, 2'd0, 16'h0001);
        @(posedge wb_clk_i);
        #1;
        gpio_in[0] = 1'b1;
        repeat (int'(v.pulse)) @(posedge wb_clk_i);
        #1;
        gpio_in[0] = 1'b0;
        repeat (40) @(posedge wb_clk_i);
        bus_read(4'd9, 2'd0, q);
        check_output($sformatf("filter_pulse%0d_div%0d", v.pulse, v.div), 64'(q[0]), 64'(v.expect_stat));
        bus_write(4'd9, 2'd0, 16'h0001);
    endtask

    // Main sequence
    initial begin
        logic [15:0] q;
        int          lat;
        int          set_edge;

        vecs[0] = '{pulse: 8'd1, div: 16'd0, expect_stat: 1'b0};
        vecs[1] = '{pulse: 8'd2, div: 16'd0, expect_stat: 1'b0};
        vecs[2] = '{pulse: 8'd3, div: 16'd0, expect_stat: 1'b1};
        vecs[3] = '{pulse: 8'd5, div: 16'd0, expect_stat: 1'b1};
        vecs[4] = '{pulse: 8'd4, div: 16'd1, expect_stat: 1'b0};
        vecs[5] = '{pulse: 8'd6, div: 16'd1, expect_stat: 1'b1};
        vecs[6] = '{pulse: 8'd6, div: 16'd2, expect_stat: 1'b0};
        vecs[7] = '{pulse: 8'd9, div: 16'd2, expect_stat: 1'b1};

        // Reset with a read strobe held: no ack while in reset, then a normal ack after release
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = {10'h0, 2'd0, 4'd1};
        repeat (3) @(posedge wb_clk_i);
        #1;
        check_output("ack_in_reset", 64'(wb_ack_o), 64'd0);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        check_output("ack_after_reset", 64'(wb_ack_o), 64'd1);
        check_output("read_out_default", 64'(wb_dat_o), 64'h00A5);
        @(posedge wb_clk_i);
        #1;
        check_output("back_to_back_gap", 64'(wb_ack_o), 64'd0);
        @(posedge wb_clk_i);
        #1;
        check_output("back_to_back_ack", 64'(wb_ack_o), 64'd1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        check_output("gpio_out_default", 64'(gpio_out), 64'h00A5);
        check_output("gpio_oe_default", 64'(gpio_oe), 64'd0);
        check_output("ded_en_default", 64'(ded_en), 64'd0);
        check_output("irq_default", 64'(irq_o), 64'd0);
        for (int r = 6; r <= 9; r++) begin
            bus_read(4'(r), 2'd0, q);
            check_output($sformatf("reset_reg%0d", r), 64'(q), 64'd0);
        end

        // Plain write then atomic set/clear
        bus_write(4'd1, 2'd0, 16'h00F0);
        bus_write(4'd4, 2'd0, 16'h000F);
        bus_write(4'd5, 2'd0, 16'h0030);
        check_output("gpio_out_setclr", 64'(gpio_out), 64'h00CF);
        bus_read(4'd1, 2'd0, q);
        check_output("read_out_setclr", 64'(q), 64'h00CF);
        bus_read(4'd4, 2'd0, q);
        check_output("read_out_set_zero", 64'(q), 64'd0);
        bus_read(4'd5, 2'd0, q);
        check_output("read_out_clr_zero", 64'(q), 64'd0);

        // Held rise on pin 0 reaches IN and raises the IRQ after the filter delay
        bus_write(4'd10, 2'd0, 16'h0000);
        bus_write(4'd7, 2'd0, 16'h0001);
        bus_write(4'd6, 2'd0, 16'h0001);
        @(posedge wb_clk_i);
        #1;
        gpio_in[0] = 1'b1;
        lat = 0;
        do begin
            @(posedge wb_clk_i);
            #1;
            lat++;
        end while (!irq_o && lat < 20);
        check_output("irq_latency_window", 64'(lat >= 5 && lat <= 8), 64'd1);
        bus_read(4'd2, 2'd0, q);
        check_output("in_after_hold", 64'(q), 64'h0001);
        bus_read(4'd9, 2'd0, q);
        check_output("stat_after_rise", 64'(q), 64'h0001);
        check_output("irq_after_rise", 64'(irq_o), 64'd1);

        // IRQ_EN masks the output but keeps STAT
        bus_write(4'd6, 2'd0, 16'h0000);
        @(posedge wb_clk_i);
        #1;
        check_output("irq_masked", 64'(irq_o), 64'd0);
        bus_read(4'd9, 2'd0, q);
        check_output("stat_kept_masked", 64'(q), 64'h0001);
        bus_write(4'd6, 2'd0, 16'h0001);
        @(posedge wb_clk_i);
        #1;
        check_output("irq_unmasked", 64'(irq_o), 64'd1);

        // W1C: irq lags the cleared STAT by one cycle
        bus_write(4'd9, 2'd0, 16'h0001);
        check_output("irq_lag_after_w1c", 64'(irq_o), 64'd1);
        @(posedge wb_clk_i);
        #1;
        check_output("irq_cleared", 64'(irq_o), 64'd0);
        bus_read(4'd9, 2'd0, q);
        check_output("stat_cleared", 64'(q), 64'd0);

        // Falling edge with FALL_EN clear is not recorded
        gpio_in[0] = 1'b0;
        repeat (20) @(posedge wb_clk_i);
        bus_read(4'd9, 2'd0, q);
        check_output("fall_not_enabled", 64'(q), 64'd0);

        // W1C landing on the same edge that records a new rise: the set must win
        set_edge = (lat >= 3 && lat < 20) ? lat - 1 : 6;
        @(posedge wb_clk_i);
        #1;
        gpio_in[0] = 1'b1;
        repeat (set_edge - 1) @(posedge wb_clk_i);
        #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = {10'h0, 2'd0, 4'd9};
        wb_dat_i = 16'h0001;
        @(posedge wb_clk_i);
        #1;
        check_output("w1c_collide_ack", 64'(wb_ack_o), 64'd1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        bus_read(4'd9, 2'd0, q);
        check_output("set_wins_over_w1c", 64'(q), 64'h0001);
        bus_write(4'd9, 2'd0, 16'h0001);
        gpio_in[0] = 1'b0;
        repeat (20) @(posedge wb_clk_i);
        bus_write(4'd9, 2'd0, 16'h0001);

        // Same sequence but clearing one edge later: the bit must end up clear
        @(posedge wb_clk_i);
        #1;
        gpio_in[0] = 1'b1;
        repeat (set_edge) @(posedge wb_clk_i);
        #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = {10'h0, 2'd0, 4'd9};
        wb_dat_i = 16'h0001;
        @(posedge wb_clk_i);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        bus_read(4'd9, 2'd0, q);
        check_output("late_w1c_clears", 64'(q), 64'd0);
        gpio_in[0] = 1'b0;
        repeat (20) @(posedge wb_clk_i);
        bus_write(4'd9, 2'd0, 16'h0001);

        // Glitch filter table
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Partial bank 2 and absent bank 3
        bus_write(4'd0, 2'd2, 16'hFFFF);
        check_output("oe_bank2_pins", 64'(gpio_oe), 64'hFF_0000_0000);
        bus_read(4'd0, 2'd2, q);
        check_output("oe_bank2_read", 64'(q), 64'h00FF);
        bus_write(4'd0, 2'd3, 16'hFFFF);
        check_output("oe_bank3_ignored", 64'(gpio_oe), 64'hFF_0000_0000);
        bus_read(4'd0, 2'd3, q);
        check_output("oe_bank3_read", 64'(q), 64'd0);
        bus_read(4'd10, 2'd1, q);
        check_output("fdiv_bank1_read", 64'(q), 64'd0);
        bus_read(4'd12, 2'd0, q);
        check_output("unmapped_read", 64'(q), 64'd0);

        // Bring everything to a known state for the randomized phase
        bus_write(4'd10, 2'd0, 16'h0000);
        for (int b = 0; b < 3; b++) begin
            bus_write(4'd0, 2'(b), 16'h0000);
            bus_write(4'd1, 2'(b), 16'h0000);
            bus_write(4'd3, 2'(b), 16'h0000);
            bus_write(4'd6, 2'(b), 16'h0000);
            bus_write(4'd7, 2'(b), 16'h0000);
            bus_write(4'd8, 2'(b), 16'h0000);
        end
        gpio_in = {8'($urandom), 32'($urandom)};
        repeat (20) @(posedge wb_clk_i);
        for (int b = 0; b < 3; b++) begin
            bus_write(4'd9, 2'(b), 16'hFFFF);
        end
        for (int r = 0; r < 16; r++) m_reg[r] = '0;
        m_reg[2] = 64'(gpio_in);
        m_fdiv   = '0;

        // Randomized register traffic against the model
        for (int n = 0; n < 300; n++) begin
            int          r;
            int          b;
            logic        we;
            logic [15:0] d;
            r  = int'($urandom_range(0, 15));
            b  = int'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            d  = 16'($urandom);
            if (r == 10) d = d & 16'h0007;
            if (we) begin
                bus_write(4'(r), 2'(b), d);
                model_write(r, b, d);
                check_output("rand_gpio_oe", 64'(gpio_oe), 64'(m_reg[0][NUM-1:0]));
                check_output("rand_gpio_out", 64'(gpio_out), 64'(m_reg[1][NUM-1:0]));
                check_output("rand_ded_en", 64'(ded_en), 64'(m_reg[3][NUM-1:0]));
            end else begin
                bus_read(4'(r), 2'(b), q);
                check_output($sformatf("rand_read_r%0d_b%0d", r, b), 64'(q), 64'(model_read(r, b)));
            end
        end
        @(posedge wb_clk_i);
        #1;
        check_output("rand_irq", 64'(irq_o), 64'(|(m_reg[9] & m_reg[6])));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
